// File: rtl/mac_rx_frame_monitor_if.sv
// RX AXI-stream beat bundle from the GTF MAC into the frame monitor.
// The MAC side drives through master; the monitor samples through slave.
interface mac_rx_frame_monitor_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  rxaxistvalid;
  logic [DATA_WIDTH-1:0] rxaxistdata;
  logic [7:0]            rxaxistlast;
  logic [1:0]            rxaxissof;
  logic                  rxaxisterr;
  logic [7:0]            pre_data_in;

  modport master (
    output rxaxistvalid, rxaxistdata, rxaxistlast, rxaxissof, rxaxisterr, pre_data_in
  );
  modport slave (
    input  rxaxistvalid, rxaxistdata, rxaxistlast, rxaxissof, rxaxisterr, pre_data_in
  );
endinterface

// File: rtl/mac_rx_frame_monitor.sv
// MAC RX frame monitor: delimits frames, checks preamble/structure, feeds the PRBS checker, keeps stats.
// All outputs registered (1 rxclk), no back-pressure; MAC_RX_TIMEOUT_EN adds a mid-frame idle timeout.
module mac_rx_frame_monitor #(
  parameter int         DATA_WIDTH   = 64,
  parameter logic [7:0] PREABLE_BYTE = 8'd3,
  parameter int         MIN_BEATS    = 2,
  parameter int         CNT_WIDTH    = 32,
  parameter int         TIMEOUT      = 255
) (
  input  logic                  rxclk,
  input  logic                  rxrst,
  input  logic                  sync,
  mac_rx_frame_monitor_if.slave rx,
  output logic                  chk_en,
  output logic [DATA_WIDTH-1:0] chk_data,
  output logic                  in_frame,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [4:0]            err_flags
);
  typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_e;

  localparam int            BW    = $clog2(MIN_BEATS + 1);
  localparam logic [BW-1:0] MIN_B = BW'(MIN_BEATS);

  state_e                state_q, state_d;
  logic [BW-1:0]         beats_q, beats_d, end_beats;
  logic                  frm_err_q, frm_err_d;
  logic                  chk_en_q, chk_en_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] chk_data_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [4:0]            flags_q, flags_d, flag_set;
  logic                  end_vld, end_err_in, errored, good_inc;
  logic [1:0]            err_inc;
  logic                  last_any, last_multi, full_beat, bad_pre;
`ifdef MAC_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign last_any   = |rx.rxaxistlast;
  assign last_multi = (rx.rxaxistlast & (rx.rxaxistlast - 8'd1)) != 8'd0;
  assign full_beat  = !last_any || (rx.rxaxistlast == 8'h80);
  assign bad_pre    = rx.pre_data_in != PREABLE_BYTE;

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    frm_err_d  = frm_err_q;
    chk_en_d   = 1'b0;
    done_d     = 1'b0;
    flag_set   = '0;
    err_inc    = 2'd0;
    good_inc   = 1'b0;
    end_vld    = 1'b0;
    end_beats  = beats_q;
    end_err_in = frm_err_q;
    errored    = 1'b0;
`ifdef MAC_RX_TIMEOUT_EN
    idle_d     = idle_q;
`endif
    if (rx.rxaxistvalid) begin
`ifdef MAC_RX_TIMEOUT_EN
      idle_d = '0;
`endif
      if (rx.rxaxissof[0]) begin
        // A SOF inside a frame closes the old frame as errored, then restarts.
        if (state_q == DATA) begin
          flag_set[0] = 1'b1;
          done_d      = 1'b1;
          err_inc     = 2'd1;
        end
        flag_set[1] = bad_pre;
        frm_err_d   = bad_pre;
        beats_d     = BW'(1);
        chk_en_d    = full_beat;
        end_beats   = BW'(1);
        end_err_in  = bad_pre;
        end_vld     = last_any;
        state_d     = last_any ? IDLE : DATA;
      end else begin
        unique case (state_q)
          IDLE: begin
            flag_set[0] = 1'b1;
            state_d     = last_any ? IDLE : DRAIN;
          end
          DATA: begin
            beats_d   = (beats_q < MIN_B) ? beats_q + BW'(1) : beats_q;
            chk_en_d  = full_beat;
            end_beats = beats_d;
            end_vld   = last_any;
            if (last_any) state_d = IDLE;
          end
          default: if (last_any) state_d = IDLE;
        endcase
      end
    end
`ifdef MAC_RX_TIMEOUT_EN
    else if (state_q == DATA) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        flag_set[4] = 1'b1;
        done_d      = 1'b1;
        err_inc     = 2'd1;
        state_d     = IDLE;
        idle_d      = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
`endif
    if (end_vld) begin
      flag_set[2] = end_beats < MIN_B;
      flag_set[3] = rx.rxaxisterr;
      flag_set[0] = flag_set[0] | last_multi;
      errored     = end_err_in | (end_beats < MIN_B) | rx.rxaxisterr | last_multi;
      done_d      = 1'b1;
      if (errored) err_inc  = err_inc + 2'd1;
      else         good_inc = 1'b1;
    end
    frame_cnt_d = sync ? '0 : sat_add(frame_cnt_q, {1'b0, good_inc});
    err_cnt_d   = sync ? '0 : sat_add(err_cnt_q, err_inc);
    flags_d     = sync ? '0 : (flags_q | flag_set);
  end

  always_ff @(posedge rxclk or posedge rxrst) begin
    if (rxrst) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      frm_err_q   <= 1'b0;
      chk_en_q    <= 1'b0;
      done_q      <= 1'b0;
      chk_data_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      flags_q     <= '0;
`ifdef MAC_RX_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      frm_err_q   <= frm_err_d;
      chk_en_q    <= chk_en_d;
      done_q      <= done_d;
      chk_data_q  <= rx.rxaxistdata;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      flags_q     <= flags_d;
`ifdef MAC_RX_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign chk_en     = chk_en_q;
  assign chk_data   = chk_data_q;
  assign in_frame   = (state_q == DATA);
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_flags  = flags_q;
endmodule

// File: tb/tb_mac_rx_frame_monitor.sv
// Bench for mac_rx_frame_monitor: directed frame scenarios plus randomized beats against a frame-level model.
// Honours MAC_RX_TIMEOUT_EN the same way the design does.
module tb_mac_rx_frame_monitor;
  localparam int DW   = 64;
  localparam int MINB = 2;
  localparam int CW   = 4;
  localparam int TO   = 20;
  localparam int CMAX = (1 << CW) - 1;
`ifdef MAC_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          rxclk = 1'b0;
  logic          rxrst = 1'b0;
  logic          sync  = 1'b0;
  logic          chk_en, in_frame, frame_done;
  logic [DW-1:0] chk_data;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic [4:0]    err_flags;

  always #5 rxclk = ~rxclk;

  mac_rx_frame_monitor_if #(.DATA_WIDTH(DW)) rx_if ();

  mac_rx_frame_monitor #(
    .DATA_WIDTH(DW), .PREABLE_BYTE(8'd3), .MIN_BEATS(MINB), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .rxclk(rxclk), .rxrst(rxrst), .sync(sync), .rx(rx_if),
    .chk_en(chk_en), .chk_data(chk_data), .in_frame(in_frame), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_flags(err_flags)
  );

  int n_cmp = 0, n_bad = 0, n_chk = 0, n_done = 0;

  // Reference model: frame-level view of the stream plus expected registered outputs.
  bit          m_in, m_drain, m_bad;
  int          m_beats, m_idle;
  bit          e_chk_en, e_done;
  logic [63:0] e_chk_data;
  int          e_fc, e_ec;
  logic [4:0]  e_fl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("chk_en",     64'(chk_en),     64'(e_chk_en));
    check("chk_data",   chk_data,        e_chk_data);
    check("frame_done", 64'(frame_done), 64'(e_done));
    check("in_frame",   64'(in_frame),   64'(m_in));
    check("frame_cnt",  64'(frame_cnt),  64'(e_fc));
    check("err_cnt",    64'(err_cnt),    64'(e_ec));
    check("err_flags",  64'(err_flags),  64'(e_fl));
    if (chk_en)     n_chk++;
    if (frame_done) n_done++;
  endtask

  task automatic model_reset();
    m_in = 0; m_drain = 0; m_bad = 0; m_beats = 0; m_idle = 0;
    e_chk_en = 0; e_done = 0; e_chk_data = '0; e_fc = 0; e_ec = 0; e_fl = '0;
  endtask

  task automatic model_apply(input bit v, input bit sof0, input logic [7:0] last, input bit err,
                             input logic [7:0] pre, input logic [63:0] data, input bit sy);
    int         good, bad;
    bit         ends, errs;
    logic [4:0] fl;
    good = 0; bad = 0; ends = 0; fl = '0;
    e_chk_en = 0; e_done = 0; e_chk_data = data;
    if (v) begin
      m_idle = 0;
      if (sof0) begin
        if (m_in) begin fl[0] = 1; e_done = 1; bad++; end
        m_in = 1; m_drain = 0; m_beats = 1; m_bad = (pre != 8'd3);
        if (m_bad) fl[1] = 1;
        e_chk_en = (last == 8'h00 || last == 8'h80);
        ends = (last != 8'h00);
      end else if (m_in) begin
        m_beats++;
        e_chk_en = (last == 8'h00 || last == 8'h80);
        ends = (last != 8'h00);
      end else if (m_drain) begin
        if (last != 8'h00) m_drain = 0;
      end else begin
        fl[0] = 1;
        m_drain = (last == 8'h00);
      end
    end else if (TO_EN && m_in) begin
      m_idle++;
      if (m_idle == TO) begin fl[4] = 1; e_done = 1; bad++; m_in = 0; m_idle = 0; end
    end
    if (ends) begin
      e_done = 1;
      errs = m_bad;
      if (m_beats < MINB)           begin fl[2] = 1; errs = 1; end
      if (err)                      begin fl[3] = 1; errs = 1; end
      if ($countones(last) > 1)     begin fl[0] = 1; errs = 1; end
      if (errs) bad++; else good++;
      m_in = 0;
    end
    if (sy) begin
      e_fc = 0; e_ec = 0; e_fl = '0;
    end else begin
      e_fc = (e_fc + good > CMAX) ? CMAX : e_fc + good;
      e_ec = (e_ec + bad  > CMAX) ? CMAX : e_ec + bad;
      e_fl = e_fl | fl;
    end
  endtask

  task automatic step(input bit v, input logic [1:0] sof, input logic [7:0] last, input bit err,
                      input logic [7:0] pre, input bit sy);
    logic [63:0] d;
    d = {$urandom, $urandom};
    @(posedge rxclk); #1;
    compare_all();
    rx_if.rxaxistvalid = v;
    rx_if.rxaxistdata  = d;
    rx_if.rxaxistlast  = last;
    rx_if.rxaxissof    = sof;
    rx_if.rxaxisterr   = err;
    rx_if.pre_data_in  = pre;
    sync               = sy;
    model_apply(v, sof[0], last, err, pre, d, sy);
  endtask

  task automatic idle();
    step(1'b0, 2'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic clear_stats();
    step(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
    n_chk = 0; n_done = 0;
  endtask

  task automatic frame(input int n, input logic [7:0] pre, input logic [7:0] lc, input bit sy_last);
    for (int i = 0; i < n; i++)
      step(1'b1, {1'b0, i == 0}, (i == n - 1) ? lc : 8'h00, 1'b0, pre, sy_last && (i == n - 1));
  endtask

  task automatic do_reset();
    @(posedge rxclk); #1;
    compare_all();
    rxrst = 1'b1;
    rx_if.rxaxistvalid = 1'b0; rx_if.rxaxistdata = '0; rx_if.rxaxistlast = '0;
    rx_if.rxaxissof = '0; rx_if.rxaxisterr = 1'b0; rx_if.pre_data_in = '0; sync = 1'b0;
    model_reset();
    @(posedge rxclk); #1;
    compare_all();
    rxrst = 1'b0;
    model_apply(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 64'h0, 1'b0);
  endtask

  task automatic rand_frame();
    int len;
    bit stray;
    len   = $urandom_range(1, 5);
    stray = ($urandom_range(0, 11) == 0);
    for (int i = 0; i < len; i++) begin
      logic [1:0] s;
      logic [7:0] l;
      logic [7:0] p;
      while ($urandom_range(0, 9) == 0) idle();
      s = {1'($urandom), 1'b0};
      if ((i == 0 && !stray) || $urandom_range(0, 29) == 0) s[0] = 1'b1;
      l = 8'h00;
      if (i == len - 1) begin
        case ($urandom_range(0, 5))
          0:       l = 8'h80;
          1:       l = 8'($urandom_range(1, 255));
          default: l = 8'h01 << $urandom_range(0, 7);
        endcase
      end
      p = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd3;
      step(1'b1, s, l, $urandom_range(0, 7) == 0, p, $urandom_range(0, 39) == 0);
    end
  endtask

  initial begin
    rx_if.rxaxistvalid = 1'b0; rx_if.rxaxistdata = '0; rx_if.rxaxistlast = '0;
    rx_if.rxaxissof = '0; rx_if.rxaxisterr = 1'b0; rx_if.pre_data_in = '0;
    model_reset();
    #2 rxrst = 1'b1;
    repeat (2) @(posedge rxclk);
    #1 compare_all();
    rxrst = 1'b0;
    model_apply(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 64'h0, 1'b0);

    // Good 4-beat frame, partial last beat.
    clear_stats();
    frame(4, 8'd3, 8'h02, 1'b0); idle();
    check("t1_chk_beats", 64'(n_chk), 64'd3);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_err_cnt",   64'(err_cnt), 64'd0);
    check("t1_done",      64'(n_done), 64'd1);

    // Wrong preamble.
    clear_stats();
    frame(4, 8'd5, 8'h02, 1'b0); idle();
    check("t2_bad_pre",   64'(err_flags[1]), 64'd1);
    check("t2_err_cnt",   64'(err_cnt), 64'd1);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t2_chk_beats", 64'(n_chk), 64'd3);

    // Single-beat runt.
    clear_stats();
    frame(1, 8'd3, 8'h80, 1'b0); idle();
    check("t3_runt",      64'(err_flags[2]), 64'd1);
    check("t3_err_cnt",   64'(err_cnt), 64'd1);
    check("t3_chk_beats", 64'(n_chk), 64'd1);

    // Stray beats without SOF, then a good frame.
    clear_stats();
    step(1'b1, 2'b00, 8'h00, 1'b0, 8'd3, 1'b0);
    step(1'b1, 2'b00, 8'h00, 1'b0, 8'd3, 1'b0);
    step(1'b1, 2'b00, 8'h01, 1'b0, 8'd3, 1'b0);
    frame(2, 8'd3, 8'h80, 1'b0); idle();
    check("t4_framing",   64'(err_flags[0]), 64'd1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t4_err_cnt",   64'(err_cnt), 64'd0);
    check("t4_chk_beats", 64'(n_chk), 64'd2);

    // Saturation, then sync against a same-cycle frame end.
    clear_stats();
    repeat (CMAX + 1) frame(2, 8'd3, 8'h80, 1'b0);
    idle();
    check("t5_saturate", 64'(frame_cnt), 64'(CMAX));
    frame(2, 8'd3, 8'h80, 1'b1); idle();
    check("t5_sync_wins", 64'(frame_cnt), 64'd0);

    // Mid-frame idle gap longer than TIMEOUT.
    clear_stats();
    step(1'b1, 2'b01, 8'h00, 1'b0, 8'd3, 1'b0);
    repeat (TO + 1) idle();
`ifdef MAC_RX_TIMEOUT_EN
    check("t6_in_frame", 64'(in_frame), 64'd0);
    check("t6_timeout",  64'(err_flags[4]), 64'd1);
    check("t6_err_cnt",  64'(err_cnt), 64'd1);
`else
    check("t6_in_frame", 64'(in_frame), 64'd1);
    step(1'b1, 2'b00, 8'h80, 1'b0, 8'd3, 1'b0); idle();
    check("t6_timeout",   64'(err_flags[4]), 64'd0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
`endif

    // Reset mid-frame: following beats without SOF are framing errors.
    step(1'b1, 2'b01, 8'h00, 1'b0, 8'd3, 1'b0);
    do_reset();
    step(1'b1, 2'b00, 8'h00, 1'b0, 8'd3, 1'b0);
    step(1'b1, 2'b00, 8'h04, 1'b0, 8'd3, 1'b0);
    idle();
    check("t7_framing",   64'(err_flags[0]), 64'd1);
    check("t7_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t7_in_frame",  64'(in_frame), 64'd0);

    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rand_frame();
    end
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
